// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end that sequences one shared combinational ALU.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/grant_cnt1).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_aluc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_aluc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_r,
  output logic [3:0]       rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic             last_grant_reg;
  logic             grant_next;
  logic             accept;
  logic [1:0]       ready_vec;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_aluc;

  // On a tie the requester that lost last time wins; otherwise the lone requester wins.
  always_comb begin
    grant_next = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_next = ~last_grant_reg;
    end else if (req1_valid) begin
      grant_next = 1'b1;
    end
  end

  assign accept   = (state_reg == IDLE) && (req0_valid || req1_valid);
  assign sel_a    = grant_next ? req1_a    : req0_a;
  assign sel_b    = grant_next ? req1_b    : req0_b;
  assign sel_aluc = grant_next ? req1_aluc : req0_aluc;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_ready
      assign ready_vec[gi] = accept && (grant_next == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_aluc       <= '0;
      rsp_id         <= 1'b0;
      rsp_r          <= '0;
      rsp_flags      <= '0;
      rsp_valid      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            alu_a          <= sel_a;
            alu_b          <= sel_b;
            alu_aluc       <= sel_aluc;
            rsp_id         <= grant_next;
            last_grant_reg <= grant_next;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          // ALU has had a full cycle to settle from the operand registers.
          rsp_r     <= alu_r;
          rsp_flags <= {alu_zero, alu_negative, alu_carry, alu_overflow};
          rsp_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt_vec [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : gen_stats
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (ready_vec[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign grant_cnt0 = cnt_vec[0];
  assign grant_cnt1 = cnt_vec[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: adder ALU stub, per-cycle comparison against a transaction-level model,
// plus directed vectors with hand-computed results.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_aluc, req1_aluc;
  logic [W-1:0] alu_a, alu_b, alu_r, rsp_r;
  logic [3:0]   alu_aluc, rsp_flags;
  logic         alu_zero, alu_negative, alu_carry, alu_overflow;
  logic         rsp_valid, rsp_ready, rsp_id;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
    .alu_zero(alu_zero), .alu_negative(alu_negative), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_flags(rsp_flags)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // ALU stub: adder, aluc ignored.
  logic [W:0] stub_sum;
  assign stub_sum     = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_r        = stub_sum[W-1:0];
  assign alu_carry    = stub_sum[W];
  assign alu_zero     = (stub_sum[W-1:0] == '0);
  assign alu_negative = stub_sum[W-1];
  assign alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (stub_sum[W-1] != alu_a[W-1]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {flags, result} of a + b, from plain integer arithmetic.
  function automatic logic [35:0] add_model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned us;
    longint          ss;
    logic [31:0]     r;
    logic            z, n, c, v;
    us = {32'b0, a} + {32'b0, b};
    ss = longint'($signed(a)) + longint'($signed(b));
    r  = us[31:0];
    z  = (r == 32'd0);
    n  = r[31];
    c  = (us >= 64'h1_0000_0000);
    v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {z, n, c, v, r};
  endfunction

  // Transaction-level model: one op in flight from accept until the response is taken.
  bit          m_busy = 0;
  int          m_age = 0;
  int          m_last = 1;
  logic [31:0] m_op_a = '0, m_op_b = '0;
  bit          m_op_id = 0;
  logic [31:0] m_alu_a = '0, m_alu_b = '0;
  logic [3:0]  m_alu_aluc = '0;
  int          m_cnt [2] = '{0, 0};
  int          win;
  int          cyc = 0;
  bit          log_pend = 0;
  int          acc_id [$];
  int          acc_cyc [$];
  int          acc_aluc [$];
  logic [35:0] m_exp;

  initial begin
    forever begin
      @(negedge clk);
      win = -1;
      if (!rst_n) begin
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_aluc", alu_aluc, 0);
      end else begin
        if (!m_busy) begin
          if (req0_valid && req1_valid) win = (m_last == 1) ? 0 : 1;
          else if (req0_valid) win = 0;
          else if (req1_valid) win = 1;
        end
        check("req0_ready", req0_ready, win == 0);
        check("req1_ready", req1_ready, win == 1);
        check("rsp_valid", rsp_valid, m_busy && m_age >= 1);
        if (m_busy && m_age >= 1) begin
          m_exp = add_model(m_op_a, m_op_b);
          check("rsp_id", rsp_id, m_op_id);
          check("rsp_r", rsp_r, m_exp[31:0]);
          check("rsp_flags", rsp_flags, m_exp[35:32]);
        end
        check("alu_a", alu_a, m_alu_a);
        check("alu_b", alu_b, m_alu_b);
        check("alu_aluc", alu_aluc, m_alu_aluc);
      end
`ifdef ALU_ARB_STATS_EN
      check("grant_cnt0", grant_cnt0, m_cnt[0]);
      check("grant_cnt1", grant_cnt1, m_cnt[1]);
`endif
      if (log_pend) begin
        acc_aluc.push_back(int'(alu_aluc));
        log_pend = 0;
      end
      if (win >= 0) begin
        acc_id.push_back(win);
        acc_cyc.push_back(cyc);
        log_pend = 1;
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_age = 0; m_last = 1;
        m_alu_a = '0; m_alu_b = '0; m_alu_aluc = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (!m_busy) begin
        if (win >= 0) begin
          m_op_a     = (win == 0) ? req0_a : req1_a;
          m_op_b     = (win == 0) ? req0_b : req1_b;
          m_alu_aluc = (win == 0) ? req0_aluc : req1_aluc;
          m_op_id    = (win == 1);
          m_alu_a    = m_op_a;
          m_alu_b    = m_op_b;
          m_last     = win;
          m_busy     = 1;
          m_age      = 0;
          if (m_cnt[win] < 65535) m_cnt[win]++;
        end
      end else if (m_age >= 1 && rsp_ready) begin
        m_busy = 0;
      end else begin
        m_age++;
      end
    end
  end

  // One operation with rsp_ready high; starts and ends just after a rising edge.
  task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] aluc, input logic [31:0] er, input logic [3:0] ef);
    rsp_ready = 1'b1;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = aluc;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_aluc = aluc;
    end
    @(negedge clk);
    check("op_ready_same_cycle", id ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("op_exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    check("op_rsp_valid", rsp_valid, 1);
    check("op_rsp_id", rsp_id, id);
    check("op_rsp_r", rsp_r, er);
    check("op_rsp_flags", rsp_flags, ef);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_aluc = '0;
    req1_a = '0; req1_b = '0; req1_aluc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_r", rsp_r, 0);
    check("reset_rsp_flags", rsp_flags, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_aluc", alu_aluc, 0);
    rst_n = 1'b1;

    // Single op and flag corner cases; the last op comes from req1 so a tie then favours req0.
    do_op(1'b0, 32'h0000_0011, 32'hFFFF_FFFE, 4'h0, 32'h0000_000F, 4'b0010);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'h2, 32'h8000_0000, 4'b0101);
    do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'h7, 32'h0000_0000, 4'b1010);

    // Tie: both requesters valid continuously.
    acc_id.delete(); acc_cyc.delete(); acc_aluc.delete();
    req0_a = 32'd1;  req0_b = 32'd2;  req0_aluc = 4'h3;
    req1_a = 32'd10; req1_b = 32'd20; req1_aluc = 4'h5;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("tie_grant_count", acc_id.size(), 4);
    for (int k = 0; k < 4 && k < acc_id.size(); k++) begin
      check("tie_grant_id", acc_id[k], k % 2);
      if (k < acc_aluc.size()) check("tie_alu_aluc", acc_aluc[k], (k % 2 == 1) ? 5 : 3);
      if (k > 0) check("tie_accept_spacing", acc_cyc[k] - acc_cyc[k-1], 3);
    end

    // Back-pressure: response held 5 cycles with both requesters waiting.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_aluc = 4'h1;
    @(negedge clk);
    check("bp_accept_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("bp_exec_ready0", req0_ready, 0);
    check("bp_exec_ready1", req1_ready, 0);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_r", rsp_r, 32'd11);
      check("bp_rsp_flags", rsp_flags, 4'b0000);
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
      @(posedge clk);
    end
    #1;
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("bp_release_still_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_back_to_idle", rsp_valid, 0);
    @(posedge clk); #1;

    // Reset during EXEC discards the op.
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_aluc = 4'hC;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_alu_b", alu_b, 0);
    check("midrst_alu_aluc", alu_aluc, 0);
    check("midrst_rsp_r", rsp_r, 0);
    check("midrst_rsp_flags", rsp_flags, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_response", rsp_valid, 0);
    @(posedge clk); #1;
    do_op(1'b1, 32'h0000_0020, 32'h0000_0022, 4'h9, 32'h0000_0042, 4'b0000);

`ifdef ALU_ARB_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) do_op(1'b0, 32'd1, 32'd1, 4'h0, 32'd2, 4'b0000);
    for (int k = 0; k < 2; k++) do_op(1'b1, 32'd2, 32'd2, 4'h0, 32'd4, 4'b0000);
    check("stats_cnt0", grant_cnt0, 16'd3);
    check("stats_cnt1", grant_cnt1, 16'd2);
    dut.gen_stats[0].cnt_reg = 16'hFFFE;
    m_cnt[0] = 65534;
    do_op(1'b0, 32'd1, 32'd1, 4'h0, 32'd2, 4'b0000);
    do_op(1'b0, 32'd1, 32'd1, 4'h0, 32'd2, 4'b0000);
    check("stats_saturate", grant_cnt0, 16'hFFFF);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
